cache_fill_responder: RTL and testbench

Memory-side responder for the cache block-fill protocol. The cache miss path requests a 16-byte block (eight 16-bit words). This block returns the eight words in order with a per-word valid strobe, after a fixed access latency. It also accepts single-word writes, which load memory contents and carry write-through traffic. It holds the backing word store and the pipelined latency model. It sits between the cache fill logic and the rest of the memory system.

---
 rtl/cache_fill_responder.sv | 128 ++++++++++++
 tb/tb_cache_fill_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_responder.sv
// Memory-side responder for cache block fills: returns an aligned eight-word
// block in address order after a fixed latency, and accepts single-word writes.
module cache_fill_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill_req,
  input  logic [15:0] fill_addr,
  output logic        fill_ack,
  output logic        mem_busy,
  output logic        mem_data_valid,
  output logic [15:0] mem_data,
  output logic [15:0] mem_data_addr,
  output logic        fill_done,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data
);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [15:0] mem [WORDS];

  state_t      state_q, state_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] iss_addr;
  beat_t       iss, out;

  // Unused address bits: block offset on requests, byte lane and aliased upper bits on writes.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fill_addr[3:0], wr_addr[0], wr_addr[15:DEPTH_LOG2+1]};

  // Store write happens at the clock edge, so a same-cycle issue still sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[DEPTH_LOG2:1]] <= wr_data;
  end

  assign iss_addr = {base_q, k_q[2:0], 1'b0};

  always_comb begin
    iss = '0;
    if (state_q == BURST && !k_q[3]) begin
      iss.valid = 1'b1;
      iss.last  = (k_q[2:0] == 3'd7);
      iss.addr  = iss_addr;
      iss.data  = mem[iss_addr[DEPTH_LOG2:1]];
    end
  end

  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign out = iss;
    end else begin : g_pipe
      localparam int PD = LATENCY - 1;
      beat_t pipe_q [PD];
      beat_t pipe_d [PD];

      always_comb begin
        pipe_d[0] = iss;
        for (int unsigned i = 1; i < PD; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < PD; i++) pipe_q[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < PD; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign out = pipe_q[PD-1];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    k_d      = k_q;
    fill_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        fill_ack = fill_req & rst_n;
        if (fill_req) begin
          state_d = BURST;
          base_d  = fill_addr[15:4];
          k_d     = '0;
        end
      end
      BURST: begin
        if (!k_q[3]) k_d = k_q + 4'd1;
        // Stay busy until the final word has left the delay pipeline.
        if (out.valid && out.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
    end
  end

  assign mem_busy       = (state_q == BURST);
  assign mem_data_valid = out.valid;
  assign mem_data       = out.data;
  assign mem_data_addr  = out.addr;
  assign fill_done      = out.valid & out.last;

endmodule

// File: tb/tb_cache_fill_responder.sv
// Scoreboard bench for cache_fill_responder at LATENCY=4 and LATENCY=1,
// sharing one stimulus stream and one reference word store.
module tb_cache_fill_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fill_req;
  logic [15:0] fill_addr;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  logic        ack_o  [2];
  logic        busy_o [2];
  logic        dv_o   [2];
  logic        done_o [2];
  logic [15:0] dd_o   [2];
  logic [15:0] da_o   [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cache_fill_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_ack(ack_o[0]), .mem_busy(busy_o[0]), .mem_data_valid(dv_o[0]),
    .mem_data(dd_o[0]), .mem_data_addr(da_o[0]), .fill_done(done_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  cache_fill_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_addr(fill_addr),
    .fill_ack(ack_o[1]), .mem_busy(busy_o[1]), .mem_data_valid(dv_o[1]),
    .mem_data(dd_o[1]), .mem_data_addr(da_o[1]), .fill_done(done_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          lat [2] = '{4, 1};
  logic [15:0] mmem [1024];
  bit          b_on [2] = '{0, 0};
  int          b_start [2];
  int          b_stop [2];
  int          b_k [2];
  logic [15:0] b_base [2];
  bit          e_ack [2] = '{0, 0};
  bit          e_busy [2] = '{0, 0};

  function automatic int qn(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qh(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpush(input int i, input exp_t e);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic qclear(input int i);
    if (i == 0) q0.delete(); else q1.delete();
  endtask

  task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", name, i, cyc, act, exp);
    end
  endtask

  // Reference model: a block accepted in cycle C streams words out at
  // C+L..C+L+7, each read from the store as it stood in cycle C+1+k.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        b_on[i]   = 0;
        e_ack[i]  = 0;
        e_busy[i] = 0;
        qclear(i);
      end else begin
        exp_t e;
        e_busy[i] = b_on[i] && cyc >= b_start[i] && cyc <= b_stop[i];
        e_ack[i]  = fill_req && !(b_on[i] && cyc <= b_stop[i]);
        if (b_on[i] && cyc >= b_start[i] && b_k[i] < 8) begin
          e.due  = cyc + lat[i] - 1;
          e.addr = b_base[i] + 16'(2 * b_k[i]);
          e.data = mmem[e.addr[10:1]];
          e.last = (b_k[i] == 7);
          qpush(i, e);
          b_k[i]++;
        end
        if (e_ack[i]) begin
          b_on[i]    = 1;
          b_start[i] = cyc + 1;
          b_stop[i]  = cyc + lat[i] + 7;
          b_k[i]     = 0;
          b_base[i]  = fill_addr & 16'hFFF0;
        end
      end
    end
    if (wr_en) mmem[wr_addr[10:1]] = wr_data;
  end

  initial forever begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      bit exp_v;
      chk("fill_ack", i, {15'd0, ack_o[i]}, {15'd0, e_ack[i]});
      chk("mem_busy", i, {15'd0, busy_o[i]}, {15'd0, e_busy[i]});
      exp_v = (qn(i) > 0) && (qh(i).due == cyc);
      chk("mem_data_valid", i, {15'd0, dv_o[i]}, {15'd0, exp_v});
      if (exp_v) begin
        exp_t e;
        e = qh(i);
        chk("mem_data", i, dd_o[i], e.data);
        chk("mem_data_addr", i, da_o[i], e.addr);
        chk("fill_done", i, {15'd0, done_o[i]}, {15'd0, e.last});
        qpop(i);
      end else begin
        chk("idle_data", i, dd_o[i], 16'h0000);
        chk("idle_addr", i, da_o[i], 16'h0000);
        chk("idle_done", i, {15'd0, done_o[i]}, 16'h0000);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rq, input logic [15:0] fa, input bit we,
                       input logic [15:0] wa, input logic [15:0] wd);
    fill_req  = rq;
    fill_addr = fa;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    tick();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(0, 16'h0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    fill_req  = 1'b0;
    fill_addr = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 256; i++) drive(0, 16'h0, 1, 16'(2 * i), 16'($urandom));

    for (int i = 0; i < 8; i++) drive(0, 16'h0, 1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
    drive(1, 16'h0105, 0, 16'h0, 16'h0);
    idle(14);

    for (int n = 0; n < 30; n++) drive(1, (n == 0) ? 16'h0000 : 16'h0010, 0, 16'h0, 16'h0);
    idle(14);

    drive(1, 16'h0100, 0, 16'h0, 16'h0);
    idle(2);
    drive(0, 16'h0, 1, 16'h0108, 16'h6666);
    drive(0, 16'h0, 1, 16'h0106, 16'h5555);
    idle(14);

    drive(1, 16'h0100, 0, 16'h0, 16'h0);
    idle(5);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    drive(1, 16'h0100, 0, 16'h0, 16'h0);
    idle(14);

    drive(0, 16'h0, 1, 16'h0800, 16'h1234);
    drive(1, 16'h0000, 0, 16'h0, 16'h0);
    idle(14);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) == 0, 16'($urandom) & 16'hF9FF,
            ($urandom % 2) == 0, 16'($urandom) & 16'hF9FF, 16'($urandom));
    end
    idle(14);

    for (int i = 0; i < 2; i++) chk("drained", i, 16'(qn(i)), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
